wb_arbiter: RTL and testbench

Writeback arbiter driving the single register-file write port of the PYGMY-V32I core. It merges single-cycle ALU results with in-order load data returning from memory, buffers load responses while the ALU owns the port, and tracks outstanding load destinations so decode can stall on RAW/WAW hazards. It sits between execute/memory and the register file, whose write port samples on the falling edge of `i_CLK`.

---
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Brief    : Writeback arbiter for the single register-file write port.
//             ALU results take priority; in-order load data is buffered and
//             retired when the port is free. Outstanding load destinations
//             are tracked so decode can stall on RAW/WAW hazards.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int QDEPTH = 4
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_ALU_VALID,
  input  logic [4:0]  i_ALU_RD_PTR,
  input  logic [31:0] i_ALU_DATA,
  input  logic        i_LD_ISSUE,
  input  logic [4:0]  i_LD_RD_PTR,
  input  logic        i_MEM_VALID,
  input  logic [31:0] i_MEM_DATA,
  input  logic [4:0]  i_RS1_PTR,
  input  logic [4:0]  i_RS2_PTR,
  input  logic [4:0]  i_DST_PTR,
  output logic        o_WE,
  output logic [4:0]  o_RD_PTR,
  output logic [31:0] o_RD,
  output logic        o_STALL,
  output logic        o_LD_FULL,
  output logic        o_ERR
);

  // Pointer width indexes the buffers; count width can represent QDEPTH itself.
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full = CW'(QDEPTH);

  // State
  logic [4:0]    tag_mem_q  [QDEPTH];
  logic [4:0]    tag_mem_d  [QDEPTH];
  logic [31:0]   data_mem_q [QDEPTH];
  logic [31:0]   data_mem_d [QDEPTH];
  logic [AW-1:0] tag_wr_q,  tag_wr_d;
  logic [AW-1:0] data_wr_q, data_wr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;   // shared head: both FIFOs retire together
  logic [CW-1:0] lcnt_q,    lcnt_d;
  logic [CW-1:0] dcnt_q,    dcnt_d;
  logic          we_q,      we_d;
  logic [4:0]    wptr_q,    wptr_d;
  logic [31:0]   wdata_q,   wdata_d;
  logic          err_q,     err_d;

  // Per-cycle events, all judged on pre-update counts
  logic issue_ok, issue_err, resp_ok, resp_err, retire;

  assign o_LD_FULL = (lcnt_q == c_full);
  assign issue_ok  = i_LD_ISSUE  && !o_LD_FULL;
  assign issue_err = i_LD_ISSUE  &&  o_LD_FULL;
  assign resp_ok   = i_MEM_VALID && (dcnt_q < lcnt_q);
  assign resp_err  = i_MEM_VALID && !(dcnt_q < lcnt_q);
  assign retire    = !i_ALU_VALID && (dcnt_q != '0);

  // Hazard detection: compare each live tag entry against the decode pointers.
  logic [QDEPTH-1:0] hit;
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_stall
    logic [AW-1:0] offs;
    logic          live;
    // Entry is live when its distance from the head is below the tag count.
    assign offs    = AW'(gi) - rd_ptr_q;
    assign live    = ({1'b0, offs} < lcnt_q);
    assign hit[gi] = live &&
                     (((tag_mem_q[gi] == i_RS1_PTR) && (i_RS1_PTR != 5'd0)) ||
                      ((tag_mem_q[gi] == i_RS2_PTR) && (i_RS2_PTR != 5'd0)) ||
                      ((tag_mem_q[gi] == i_DST_PTR) && (i_DST_PTR != 5'd0)));
  end

  assign o_STALL = (|hit) || o_LD_FULL;

  // Next-state: FIFO pushes/pops, counts, arbitration and sticky error.
  always_comb begin
    tag_mem_d  = tag_mem_q;
    data_mem_d = data_mem_q;
    tag_wr_d   = tag_wr_q;
    data_wr_d  = data_wr_q;
    rd_ptr_d   = rd_ptr_q;
    we_d       = 1'b0;
    wptr_d     = wptr_q;
    wdata_d    = wdata_q;
    err_d      = err_q | issue_err | resp_err;

    if (issue_ok) begin
      tag_mem_d[tag_wr_q] = i_LD_RD_PTR;
      tag_wr_d            = tag_wr_q + AW'(1);
    end
    if (resp_ok) begin
      data_mem_d[data_wr_q] = i_MEM_DATA;
      data_wr_d             = data_wr_q + AW'(1);
    end

    if (i_ALU_VALID) begin
      we_d    = |i_ALU_RD_PTR;
      wptr_d  = i_ALU_RD_PTR;
      wdata_d = i_ALU_DATA;
    end else if (retire) begin
      // A load to x0 still frees its slot but never writes.
      we_d     = (tag_mem_q[rd_ptr_q] != 5'd0);
      wptr_d   = tag_mem_q[rd_ptr_q];
      wdata_d  = data_mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    lcnt_d = lcnt_q + {{AW{1'b0}}, issue_ok} - {{AW{1'b0}}, retire};
    dcnt_d = dcnt_q + {{AW{1'b0}}, resp_ok}  - {{AW{1'b0}}, retire};
  end

  // State registers; reset discards every outstanding load and buffered word.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      for (int i = 0; i < QDEPTH; i++) begin
        tag_mem_q[i]  <= 5'd0;
        data_mem_q[i] <= 32'd0;
      end
      tag_wr_q  <= '0;
      data_wr_q <= '0;
      rd_ptr_q  <= '0;
      lcnt_q    <= '0;
      dcnt_q    <= '0;
      we_q      <= 1'b0;
      wptr_q    <= 5'd0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      tag_mem_q  <= tag_mem_d;
      data_mem_q <= data_mem_d;
      tag_wr_q   <= tag_wr_d;
      data_wr_q  <= data_wr_d;
      rd_ptr_q   <= rd_ptr_d;
      lcnt_q     <= lcnt_d;
      dcnt_q     <= dcnt_d;
      we_q       <= we_d;
      wptr_q     <= wptr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign o_WE     = we_q;
  assign o_RD_PTR = wptr_q;
  assign o_RD     = wdata_q;
  assign o_ERR    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Brief    : Self-checking bench for wb_arbiter against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int QDEPTH = 4;

  logic        i_CLK = 1'b0;
  logic        i_RST = 1'b1;
  logic        i_ALU_VALID, i_LD_ISSUE, i_MEM_VALID;
  logic [4:0]  i_ALU_RD_PTR, i_LD_RD_PTR, i_RS1_PTR, i_RS2_PTR, i_DST_PTR;
  logic [31:0] i_ALU_DATA, i_MEM_DATA;
  logic        o_WE, o_STALL, o_LD_FULL, o_ERR;
  logic [4:0]  o_RD_PTR;
  logic [31:0] o_RD;

  wb_arbiter #(.QDEPTH(QDEPTH)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_ALU_VALID(i_ALU_VALID), .i_ALU_RD_PTR(i_ALU_RD_PTR), .i_ALU_DATA(i_ALU_DATA),
    .i_LD_ISSUE(i_LD_ISSUE), .i_LD_RD_PTR(i_LD_RD_PTR),
    .i_MEM_VALID(i_MEM_VALID), .i_MEM_DATA(i_MEM_DATA),
    .i_RS1_PTR(i_RS1_PTR), .i_RS2_PTR(i_RS2_PTR), .i_DST_PTR(i_DST_PTR),
    .o_WE(o_WE), .o_RD_PTR(o_RD_PTR), .o_RD(o_RD),
    .o_STALL(o_STALL), .o_LD_FULL(o_LD_FULL), .o_ERR(o_ERR)
  );

  always #5 i_CLK = ~i_CLK;

  // Reference model: outstanding destinations and returned data as queues.
  logic [4:0]  m_tags [$];
  logic [31:0] m_data [$];
  logic        m_we, m_err;
  logic [4:0]  m_ptr;
  logic [31:0] m_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_stall();
    logic s = (m_tags.size() == QDEPTH);
    foreach (m_tags[k]) begin
      if ((i_RS1_PTR != 0 && m_tags[k] == i_RS1_PTR) ||
          (i_RS2_PTR != 0 && m_tags[k] == i_RS2_PTR) ||
          (i_DST_PTR != 0 && m_tags[k] == i_DST_PTR)) s = 1'b1;
    end
    return s;
  endfunction

  task automatic clear_in();
    i_ALU_VALID = 0; i_ALU_RD_PTR = 0; i_ALU_DATA = 0;
    i_LD_ISSUE = 0;  i_LD_RD_PTR = 0;
    i_MEM_VALID = 0; i_MEM_DATA = 0;
    i_RS1_PTR = 0;   i_RS2_PTR = 0;  i_DST_PTR = 0;
  endtask

  task automatic check_outputs();
    chk("we",     {31'd0, o_WE},  {31'd0, m_we});
    chk("rd_ptr", {27'd0, o_RD_PTR}, {27'd0, m_ptr});
    chk("rd",     o_RD, m_rd);
    chk("err",    {31'd0, o_ERR}, {31'd0, m_err});
  endtask

  // Entered at a falling edge with inputs already set; leaves at the next one.
  task automatic cycle();
    logic        ld_ok, mv_ok, ret;
    logic [4:0]  ht;
    logic [31:0] hd;
    #1;
    chk("ld_full", {31'd0, o_LD_FULL}, {31'd0, (m_tags.size() == QDEPTH)});
    chk("stall",   {31'd0, o_STALL},   {31'd0, model_stall()});
    ld_ok = i_LD_ISSUE && (m_tags.size() < QDEPTH);
    mv_ok = i_MEM_VALID && (m_data.size() < m_tags.size());
    if (i_LD_ISSUE && !ld_ok) m_err = 1;
    if (i_MEM_VALID && !mv_ok) m_err = 1;
    ret = !i_ALU_VALID && (m_data.size() > 0);
    if (i_ALU_VALID) begin
      m_we = (i_ALU_RD_PTR != 0); m_ptr = i_ALU_RD_PTR; m_rd = i_ALU_DATA;
    end else if (ret) begin
      ht = m_tags.pop_front(); hd = m_data.pop_front();
      m_we = (ht != 0); m_ptr = ht; m_rd = hd;
    end else begin
      m_we = 0;
    end
    if (ld_ok) m_tags.push_back(i_LD_RD_PTR);
    if (mv_ok) m_data.push_back(i_MEM_DATA);
    @(posedge i_CLK); #1;
    check_outputs();
    @(negedge i_CLK);
  endtask

  task automatic apply_reset();
    @(negedge i_CLK);
    clear_in();
    i_RST = 1;
    m_tags.delete(); m_data.delete();
    m_we = 0; m_ptr = 0; m_rd = 0; m_err = 0;
    #1;
    check_outputs();
    chk("rst_full",  {31'd0, o_LD_FULL}, 32'd0);
    chk("rst_stall", {31'd0, o_STALL},   32'd0);
    @(negedge i_CLK);
    i_RST = 0;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) begin clear_in(); cycle(); end
  endtask

  initial begin
    clear_in();
    m_we = 0; m_ptr = 0; m_rd = 0; m_err = 0;
    apply_reset();

    // ALU write to x5
    clear_in(); i_ALU_VALID = 1; i_ALU_RD_PTR = 5; i_ALU_DATA = 32'hDEADBEEF; cycle();
    chk("alu_we", {31'd0, o_WE}, 32'd1);
    chk("alu_rd", o_RD, 32'hDEADBEEF);
    idle_n(1);

    // Loads to x3, x7; in-order responses; stall on x7 until its write appears
    clear_in(); i_LD_ISSUE = 1; i_LD_RD_PTR = 3; i_RS1_PTR = 7; cycle();
    clear_in(); i_LD_ISSUE = 1; i_LD_RD_PTR = 7; i_RS1_PTR = 7; cycle();
    clear_in(); i_MEM_VALID = 1; i_MEM_DATA = 32'h11; i_RS1_PTR = 7; cycle();
    clear_in(); i_MEM_VALID = 1; i_MEM_DATA = 32'h22; i_RS1_PTR = 7; cycle();
    clear_in(); i_RS1_PTR = 7; cycle();
    chk("x7_write", {27'd0, o_RD_PTR}, 32'd7);
    chk("x7_nostall", {31'd0, o_STALL}, 32'd0);
    idle_n(2);

    // Fill to QDEPTH, then one overflow issue
    for (int k = 0; k < QDEPTH; k++) begin
      clear_in(); i_LD_ISSUE = 1; i_LD_RD_PTR = 5'(10 + k); cycle();
    end
    clear_in(); i_LD_ISSUE = 1; i_LD_RD_PTR = 20; cycle();
    chk("ovf_err", {31'd0, o_ERR}, 32'd1);
    // Two responses arrive under three ALU cycles; nothing is lost
    clear_in(); i_MEM_VALID = 1; i_MEM_DATA = 32'hA0; i_ALU_VALID = 1; i_ALU_RD_PTR = 1; i_ALU_DATA = 32'h101; cycle();
    clear_in(); i_MEM_VALID = 1; i_MEM_DATA = 32'hA1; i_ALU_VALID = 1; i_ALU_RD_PTR = 2; i_ALU_DATA = 32'h102; cycle();
    clear_in(); i_ALU_VALID = 1; i_ALU_RD_PTR = 3; i_ALU_DATA = 32'h103; cycle();
    idle_n(3);
    for (int k = 0; k < 2; k++) begin
      clear_in(); i_MEM_VALID = 1; i_MEM_DATA = 32'hB0 + k; cycle();
    end
    idle_n(3);

    // Response with nothing outstanding
    apply_reset();
    clear_in(); i_MEM_VALID = 1; i_MEM_DATA = 32'h55; cycle();
    chk("orphan_err", {31'd0, o_ERR}, 32'd1);
    idle_n(1);

    // Load to x0
    apply_reset();
    clear_in(); i_LD_ISSUE = 1; i_LD_RD_PTR = 0; i_RS1_PTR = 0; cycle();
    clear_in(); i_MEM_VALID = 1; i_MEM_DATA = 32'hFFFF; i_RS1_PTR = 0; cycle();
    clear_in(); cycle();
    chk("x0_we", {31'd0, o_WE}, 32'd0);
    idle_n(1);

    // Randomized traffic, with one mid-run reset
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      for (int n = 0; n < 300; n++) begin
        clear_in();
        i_ALU_VALID  = ($urandom_range(0, 2) == 0);
        i_ALU_RD_PTR = 5'($urandom_range(0, 7));
        i_ALU_DATA   = $urandom;
        i_LD_ISSUE   = (m_tags.size() < QDEPTH) ? ($urandom_range(0, 2) == 0)
                                                : ($urandom_range(0, 40) == 0);
        i_LD_RD_PTR  = 5'($urandom_range(0, 7));
        i_MEM_VALID  = (m_data.size() < m_tags.size()) ? ($urandom_range(0, 1) == 0)
                                                       : ($urandom_range(0, 60) == 0);
        i_MEM_DATA   = $urandom;
        i_RS1_PTR    = 5'($urandom_range(0, 7));
        i_RS2_PTR    = 5'($urandom_range(0, 7));
        i_DST_PTR    = 5'($urandom_range(0, 7));
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
